rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8_pkg.sv | 22 ++
 rtl/rr_arbiter8_mux81.sv | 13 +
 rtl/rr_arbiter8.sv | 111 +++++++++++
 tb/tb_rr_arbiter8.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
// Requester count, select width, FSM encoding, one-hot helper.
package rr_arbiter8_pkg;

  localparam int NREQ = 8;
  localparam int SELW = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NREQ-1:0] idx2oh(
    input logic [SELW-1:0] idx
  );
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter8_mux81.sv
// Existing 8:1 data mux; s0 is the most significant select bit.
// Pure combinational, no gating.
module mux81 (
  input  logic [7:0] d,
  input  logic       s0,
  input  logic       s1,
  input  logic       s2,
  output logic       y
);

  assign y = d[{s0, s1, s2}];

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with bounded hold time.
// Registered one-hot grant, index and a valid-gated data mux.
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] din,
  output logic [NREQ-1:0] grant,
  output logic [SELW-1:0] sel,
  output logic            valid,
  output logic            y,
  output logic            busy
);

  localparam logic [3:0] HMAX = 4'(MAX_HOLD - 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] last_q, last_d;
  logic [3:0]      hcnt_q, hcnt_d;

  logic            pick_vld;
  logic [SELW-1:0] pick_idx;
  logic            others;
  logic            mux_y;

  // Rotating first-set search starting just after the last served.
  always_comb begin
    logic [SELW-1:0] cand;
    pick_vld = 1'b0;
    pick_idx = last_q;
    cand     = last_q;
    for (int i = 1; i <= NREQ; i++) begin
      cand = last_q + SELW'(i);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign others = |(req & ~grant_q);

  // Next-state: start, hold, or release the current grant.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hcnt_d  = hcnt_q;
    unique case (state_q)
      IDLE: begin
        if (en && pick_vld) begin
          state_d = GRANT;
          grant_d = idx2oh(pick_idx);
          sel_d   = pick_idx;
          hcnt_d  = '0;
        end
      end
      GRANT: begin
        if (!req[sel_q] || (hcnt_q == HMAX && others)) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = sel_q;
          hcnt_d  = '0;
        end else if (hcnt_q != HMAX) begin
          hcnt_d = hcnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      last_q  <= SELW'(NREQ - 1);
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hcnt_q  <= hcnt_d;
    end
  end

  mux81 u_mux (
    .d  (din),
    .s0 (sel_q[2]),
    .s1 (sel_q[1]),
    .s2 (sel_q[0]),
    .y  (mux_y)
  );

  assign grant = grant_q;
  assign sel   = sel_q;
  assign valid = (state_q == GRANT);
  assign busy  = (state_q == GRANT);
  assign y     = valid & mux_y;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random
// traffic against a cycle-level round-robin model.
module tb_rr_arbiter8;

  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] din = 8'h00;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       valid;
  logic       y;
  logic       busy;

  int checks = 0;
  int failures = 0;

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req),
    .din   (din),
    .grant (grant),
    .sel   (sel),
    .valid (valid),
    .y     (y),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int owner;
    int last;
    int held;
  } ms_t;

  ms_t ms = '{owner: -1, last: 7, held: 0};

  function automatic ms_t model_step(ms_t s, logic e, logic [7:0] r);
    ms_t n = s;
    if (s.owner < 0) begin
      if (e && r != 8'h00) begin
        for (int off = 1; off <= 8; off++) begin
          int k = (s.last + off) % 8;
          if (r[k]) begin
            n.owner = k;
            n.held = 1;
            break;
          end
        end
      end
    end else begin
      logic [7:0] oth = r;
      oth[s.owner] = 1'b0;
      if (!r[s.owner] || (s.held >= MH && oth != 8'h00)) begin
        n.last = s.owner;
        n.owner = -1;
        n.held = 0;
      end else begin
        n.held = s.held + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ms <= '{owner: -1, last: 7, held: 0};
    else ms <= model_step(ms, en, req);
  end

  function automatic int oh2idx(logic [7:0] g);
    int r = -1;
    for (int i = 0; i < 8; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic idle_out(int n);
    req = 8'h00;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({grant, valid, busy, y, sel} !== 14'h0) begin
      failures++;
      $display("FAIL reset_state got g=%h v=%b b=%b y=%b s=%0d want all 0",
               grant, valid, busy, y, sel);
    end
  endtask

  task automatic test_single();
    rst_n = 1'b1;
    en = 1'b1;
    req = 8'h01;
    din = 8'($urandom);
    @(negedge clk);
    checks++;
    if (grant !== 8'h01 || sel !== 3'd0 || valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_grant got g=%h s=%0d v=%b b=%b want 01/0/1/1",
               grant, sel, valid, busy);
    end
    checks++;
    if (y !== din[0]) begin
      failures++;
      $display("FAIL single_y got %b want %b", y, din[0]);
    end
    din = ~din;
    #1;
    checks++;
    if (y !== din[0]) begin
      failures++;
      $display("FAIL single_y_follow got %b want %b", y, din[0]);
    end
    req = 8'h00;
    @(negedge clk);
    checks++;
    if (grant !== 8'h00 || valid !== 1'b0 || y !== 1'b0) begin
      failures++;
      $display("FAIL single_release got g=%h v=%b y=%b want 00/0/0",
               grant, valid, y);
    end
    @(negedge clk);
  endtask

  task automatic test_rotation();
    int cur = -1;
    int len = 0;
    int gap = 0;
    int n = 0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    en = 1'b1;
    req = 8'hFF;
    for (int c = 0; c < 120 && n < 9; c++) begin
      @(negedge clk);
      if (grant != 8'h00) begin
        if (cur < 0) begin
          if (n > 0) begin
            checks++;
            if (gap != 1) begin
              failures++;
              $display("FAIL rot_gap got %0d idle cycles want 1", gap);
            end
          end
          cur = oh2idx(grant);
          len = 1;
        end else begin
          len++;
        end
        gap = 0;
      end else begin
        if (cur >= 0) begin
          checks++;
          if (cur != n % 8 || len != MH) begin
            failures++;
            $display("FAIL rot_run%0d got idx=%0d len=%0d want idx=%0d len=%0d",
                     n, cur, len, n % 8, MH);
          end
          n++;
          cur = -1;
        end
        gap++;
      end
    end
    checks++;
    if (n != 9) begin
      failures++;
      $display("FAIL rot_timeout got %0d runs want 9", n);
    end
    idle_out(2);
  endtask

  task automatic test_hold();
    int bad = 0;
    en = 1'b1;
    req = 8'h20;
    repeat (20) begin
      @(negedge clk);
      if (grant !== 8'h20 || sel !== 3'd5) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL hold_cont got %0d bad cycles want 0", bad);
    end
    req = 8'h00;
    @(negedge clk);
    checks++;
    if (grant !== 8'h00 || valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_release got g=%h v=%b want 00/0", grant, valid);
    end
    req = 8'h61;
    @(negedge clk);
    checks++;
    if (grant !== 8'h40) begin
      failures++;
      $display("FAIL hold_last got g=%h want 40", grant);
    end
    idle_out(2);
  endtask

  task automatic test_skip();
    req = 8'h04;
    @(negedge clk);
    checks++;
    if (grant !== 8'h04) begin
      failures++;
      $display("FAIL skip_start got g=%h want 04", grant);
    end
    req = 8'h42;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 8'h40 || sel !== 3'd6) begin
      failures++;
      $display("FAIL skip_next got g=%h s=%0d want 40/6", grant, sel);
    end
    idle_out(2);
  endtask

  task automatic test_en_low();
    int bad = 0;
    en = 1'b1;
    req = 8'h08;
    @(negedge clk);
    checks++;
    if (grant !== 8'h08) begin
      failures++;
      $display("FAIL enlow_start got g=%h want 08", grant);
    end
    en = 1'b0;
    repeat (MH + 4) begin
      @(negedge clk);
      if (grant !== 8'h08) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL enlow_keep got %0d bad cycles want 0", bad);
    end
    req = 8'h11;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (grant !== 8'h00 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL enlow_block got %0d bad cycles want 0", bad);
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 8'h10) begin
      failures++;
      $display("FAIL enlow_resume got g=%h want 10", grant);
    end
    idle_out(2);
  endtask

  task automatic test_random();
    int bad = 0;
    logic [7:0] eg;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      eg = (ms.owner >= 0) ? (8'h01 << ms.owner) : 8'h00;
      checks++;
      if (grant !== eg || valid !== (ms.owner >= 0) || busy !== (ms.owner >= 0)
          || (ms.owner >= 0 && sel !== 3'(ms.owner))
          || y !== ((ms.owner >= 0) ? din[ms.owner] : 1'b0)) begin
        failures++;
        bad++;
        if (bad < 10)
          $display("FAIL rand_c%0d got g=%h s=%0d v=%b y=%b want g=%h",
                   c, grant, sel, valid, y, eg);
      end
      if ($urandom_range(3) == 0) req = 8'($urandom) & 8'($urandom);
      en = ($urandom_range(7) != 0);
      din = 8'($urandom);
    end
    en = 1'b1;
    idle_out(2);
  endtask

  task automatic test_async_reset();
    int w = 0;
    en = 1'b1;
    din = 8'hFF;
    req = 8'hFF;
    while (valid !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (valid !== 1'b1) begin
      failures++;
      $display("FAIL areset_setup got v=%b want 1", valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 8'h00 || valid !== 1'b0 || y !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL areset_clear got g=%h v=%b y=%b b=%b want 0",
               grant, valid, y, busy);
    end
    req = 8'h80;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (grant !== 8'h00) begin
      failures++;
      $display("FAIL areset_early got g=%h want 00", grant);
    end
    @(negedge clk);
    checks++;
    if (grant !== 8'h80 || sel !== 3'd7) begin
      failures++;
      $display("FAIL areset_first got g=%h s=%0d want 80/7", grant, sel);
    end
    idle_out(2);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req = 8'h81;
    @(negedge clk);
    checks++;
    if (grant !== 8'h01) begin
      failures++;
      $display("FAIL areset_last7 got g=%h want 01", grant);
    end
    idle_out(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_hold();
    test_skip();
    test_en_low();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
